// File: rtl/fft_pkg.sv
// Shared types and arithmetic helpers for the streaming FFT frame controller.
// Helpers work on int so the same code serves every parameterisation.
package fft_pkg;

  localparam int N     = 512;
  localparam int LANES = 16;
  localparam int BEATS = N / LANES;
  localparam int LOG2N = $clog2(N);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int bitrev(input int idx, input int nbits);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < nbits) r = r | (((idx >> i) & 1) << (nbits - 1 - i));
    end
    return r;
  endfunction

  function automatic int sat_to(input int x, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Negation whose only overflow case (most negative value) clips to max.
  function automatic int neg_sat(input int x, input int w);
    return sat_to(-x, w);
  endfunction

  function automatic int shift_neg(input int x, input int sh, input logic neg);
    int s;
    s = x >>> sh;
    return neg ? -s : s;
  endfunction

endpackage

// File: rtl/fft_out_reorder.sv
// Output buffer for the core result; turns a beat pointer into one natural-order,
// scaled and saturated beat. Bypass lets beat 0 be formed straight from the core.
module fft_out_reorder #(
  parameter int N       = 512,
  parameter int LANES   = 16,
  parameter int CORE_W  = 13,
  parameter int OUT_W   = 13,
  parameter int SHIFT_W = 4,
  parameter int PTR_W   = 5
) (
  input  logic                   clk,
  input  logic                   capture_i,
  input  logic                   bypass_i,
  input  logic [N*CORE_W-1:0]    dout_re_i,
  input  logic [N*CORE_W-1:0]    dout_im_i,
  input  logic [PTR_W-1:0]       beat_i,
  input  logic [SHIFT_W-1:0]     shift_i,
  input  logic                   inverse_i,
  output logic [LANES*OUT_W-1:0] beat_re_o,
  output logic [LANES*OUT_W-1:0] beat_im_o,
  output logic                   clip_o
);
  import fft_pkg::*;

  localparam int IDX_W = $clog2(N);

  logic [N*CORE_W-1:0] buf_re_q;
  logic [N*CORE_W-1:0] buf_im_q;
  logic [N*CORE_W-1:0] src_re;
  logic [N*CORE_W-1:0] src_im;

  always_ff @(posedge clk) begin
    if (capture_i) begin
      buf_re_q <= dout_re_i;
      buf_im_q <= dout_im_i;
    end
  end

  assign src_re = bypass_i ? dout_re_i : buf_re_q;
  assign src_im = bypass_i ? dout_im_i : buf_im_q;

  always_comb begin
    beat_re_o = '0;
    beat_im_o = '0;
    clip_o    = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      int idx;
      int re_r;
      int im_r;
      int re_o;
      int im_o;
      idx  = bitrev(int'(beat_i) * LANES + l, IDX_W);
      re_r = shift_neg(int'($signed(src_re[idx*CORE_W +: CORE_W])), int'(shift_i), 1'b0);
      // Inverse mode conjugates the result: imag is negated before clipping.
      im_r = shift_neg(int'($signed(src_im[idx*CORE_W +: CORE_W])), int'(shift_i), inverse_i);
      re_o = sat_to(re_r, OUT_W);
      im_o = sat_to(im_r, OUT_W);
      beat_re_o[l*OUT_W +: OUT_W] = OUT_W'(re_o);
      beat_im_o[l*OUT_W +: OUT_W] = OUT_W'(im_o);
      if ((re_o != re_r) || (im_o != im_r)) clip_o = 1'b1;
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Streaming wrapper around a parallel FFT core: assembles frames from input beats,
// launches the core, then streams the bit-reversed result out in natural order.
module fft_frame_ctrl #(
  parameter int N       = fft_pkg::N,
  parameter int LANES   = fft_pkg::LANES,
  parameter int IN_W    = 9,
  parameter int CORE_W  = 13,
  parameter int OUT_W   = 13,
  parameter int SHIFT_W = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_re,
  input  logic [LANES*IN_W-1:0]  in_im,
  input  logic                   cfg_inverse,
  input  logic [SHIFT_W-1:0]     cfg_shift,
  output logic                   core_start,
  output logic [N*IN_W-1:0]      core_din_re,
  output logic [N*IN_W-1:0]      core_din_im,
  input  logic                   core_done,
  input  logic [N*CORE_W-1:0]    core_dout_re,
  input  logic [N*CORE_W-1:0]    core_dout_im,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_re,
  output logic [LANES*OUT_W-1:0] out_im,
  output logic                   out_last,
  output logic                   sat_flag,
  output logic [15:0]            frame_cnt
);
  import fft_pkg::*;

  localparam int NBEATS = N / LANES;
  localparam int PTR_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [PTR_W-1:0] LAST_BEAT = PTR_W'(NBEATS - 1);

  state_e                 state_q;
  logic [PTR_W-1:0]       in_ptr_q;
  logic [PTR_W-1:0]       out_ptr_q;
  logic                   inv_q;
  logic [SHIFT_W-1:0]     shift_q;
  logic                   in_ready_q;
  logic                   start_q;
  logic                   out_valid_q;
  logic                   out_last_q;
  logic                   sat_q;
  logic [15:0]            frame_cnt_q;
  logic [LANES*OUT_W-1:0] out_re_q;
  logic [LANES*OUT_W-1:0] out_im_q;
  logic [N*IN_W-1:0]      din_re_q;
  logic [N*IN_W-1:0]      din_im_q;

  logic                   in_fire;
  logic                   out_fire;
  logic                   capture;
  logic                   conj_d;
  logic [PTR_W-1:0]       out_ptr_d;
  logic [PTR_W-1:0]       rd_beat;
  logic [LANES*OUT_W-1:0] beat_re;
  logic [LANES*OUT_W-1:0] beat_im;
  logic                   beat_clip;

  // Handshakes: a beat moves on a clock edge where valid and ready are both high.
  assign in_fire   = in_valid && in_ready_q && (state_q == FILL);
  assign out_fire  = out_valid_q && out_ready;
  assign capture   = (state_q == RUN) && core_done;
  // Beat 0 of a frame uses the incoming mode, later beats the latched one.
  assign conj_d    = (in_ptr_q == '0) ? cfg_inverse : inv_q;
  assign out_ptr_d = out_ptr_q + PTR_W'(1);
  assign rd_beat   = (state_q == DRAIN) ? out_ptr_d : '0;

  fft_out_reorder #(
    .N       (N),
    .LANES   (LANES),
    .CORE_W  (CORE_W),
    .OUT_W   (OUT_W),
    .SHIFT_W (SHIFT_W),
    .PTR_W   (PTR_W)
  ) u_reorder (
    .clk       (clk),
    .capture_i (capture),
    .bypass_i  (state_q == RUN),
    .dout_re_i (core_dout_re),
    .dout_im_i (core_dout_im),
    .beat_i    (rd_beat),
    .shift_i   (shift_q),
    .inverse_i (inv_q),
    .beat_re_o (beat_re),
    .beat_im_o (beat_im),
    .clip_o    (beat_clip)
  );

  // Frame store: only written in FILL, so it is stable for the core until capture.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int l = 0; l < LANES; l++) begin
        din_re_q[(int'(in_ptr_q)*LANES + l)*IN_W +: IN_W] <= in_re[l*IN_W +: IN_W];
        din_im_q[(int'(in_ptr_q)*LANES + l)*IN_W +: IN_W] <= conj_d ?
          IN_W'(neg_sat(int'($signed(in_im[l*IN_W +: IN_W])), IN_W)) : in_im[l*IN_W +: IN_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= FILL;
      in_ptr_q    <= '0;
      out_ptr_q   <= '0;
      inv_q       <= 1'b0;
      shift_q     <= '0;
      in_ready_q  <= 1'b0;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      sat_q       <= 1'b0;
      frame_cnt_q <= '0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        FILL: begin
          in_ready_q <= 1'b1;
          if (in_fire) begin
            if (in_ptr_q == '0) begin
              inv_q   <= cfg_inverse;
              shift_q <= cfg_shift;
              sat_q   <= 1'b0;
            end
            if (in_ptr_q == LAST_BEAT) begin
              in_ptr_q   <= '0;
              in_ready_q <= 1'b0;
              start_q    <= 1'b1;
              state_q    <= RUN;
            end else begin
              in_ptr_q <= in_ptr_q + PTR_W'(1);
            end
          end
        end
        RUN: begin
          if (core_done) begin
            out_valid_q <= 1'b1;
            out_ptr_q   <= '0;
            out_re_q    <= beat_re;
            out_im_q    <= beat_im;
            out_last_q  <= (LAST_BEAT == '0);
            sat_q       <= sat_q | beat_clip;
            state_q     <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (out_ptr_q == LAST_BEAT) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_ptr_q   <= '0;
              frame_cnt_q <= frame_cnt_q + 16'd1;
              in_ready_q  <= 1'b1;
              state_q     <= FILL;
            end else begin
              out_ptr_q  <= out_ptr_d;
              out_re_q   <= beat_re;
              out_im_q   <= beat_im;
              out_last_q <= (out_ptr_d == LAST_BEAT);
              sat_q      <= sat_q | beat_clip;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign core_start  = start_q;
  assign core_din_re = din_re_q;
  assign core_din_im = din_im_q;
  assign out_valid   = out_valid_q;
  assign out_re      = out_re_q;
  assign out_im      = out_im_q;
  assign out_last    = out_last_q;
  assign sat_flag    = sat_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
